// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: per-port read tag and
// round-robin pointer advance.
package bram_arb_pkg;

    localparam int unsigned MAX_IW = 4;

    typedef struct packed {
        logic              vld;
        logic [MAX_IW-1:0] id;
    } port_tag_t;

    // Pointer moves just past the last granted requester; holds when nothing was granted.
    function automatic logic [MAX_IW-1:0] rr_next(input logic [MAX_IW-1:0] ptr,
                                                  input logic [MAX_IW-1:0] last,
                                                  input int unsigned       n,
                                                  input logic              hit);
        if (!hit) begin
            return ptr;
        end
        if (32'(last) + 32'd1 >= n) begin
            return '0;
        end
        return last + MAX_IW'(1);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the arbiter, with the arbiter as slave
// and the surrounding requesters/BRAM as master.
interface bram_port_arbiter_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_PORTS = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ-1:0][AW-1:0]      req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0]   req_din;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]   rsp_data;
    logic [NUM_PORTS-1:0][AW-1:0]    bram_addr;
    logic [NUM_PORTS-1:0]            bram_we;
    logic [NUM_PORTS-1:0][WIDTH-1:0] bram_din;
    logic [NUM_PORTS-1:0][WIDTH-1:0] bram_dout;

    modport master (
        output req_valid, req_we, req_addr, req_din, bram_dout,
        input  req_ready, rsp_valid, rsp_data, bram_addr, bram_we, bram_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din, bram_dout,
        output req_ready, rsp_valid, rsp_data, bram_addr, bram_we, bram_din
    );

endinterface

// File: rtl/bram_port_arbiter_rr_find_first.sv
// First set bit of a mask, searching upward from a start index with wrap-around.
module rr_find_first #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    int unsigned j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of a multi-port BRAM among NUM_REQ requesters, with read
// data routed back to the issuing requester one cycle after the grant.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_PORTS = 2
) (
    input logic                clk,
    input logic                reset,
    bram_port_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0]                rr_ptr;
    logic [NUM_PORTS-1:0]         port_hit;
    logic [NUM_PORTS-1:0][IW-1:0] port_id;
    port_tag_t [NUM_PORTS-1:0]    tag_q;
    logic [IW-1:0]                last_id;
    logic                         any_grant;

    // Grant chain: each port searches what earlier ports left unclaimed and conflict-free.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [NUM_REQ-1:0] taken_in;
        logic [NUM_REQ-1:0] blocked_in;
        logic [NUM_REQ-1:0] taken_out;
        logic [NUM_REQ-1:0] blocked_out;
        logic [NUM_REQ-1:0] cand;
        logic               hit;
        logic [IW-1:0]      id;

        if (k == 0) begin : g_head
            assign taken_in   = '0;
            assign blocked_in = '0;
        end else begin : g_link
            assign taken_in   = g_port[k-1].taken_out;
            assign blocked_in = g_port[k-1].blocked_out;
        end

        assign cand = reset ? (bus.req_valid & ~taken_in & ~blocked_in) : '0;

        rr_find_first #(.N(NUM_REQ)) u_find (
            .mask  (cand),
            .start (rr_ptr),
            .found (hit),
            .idx   (id)
        );

        assign taken_out = taken_in | (hit ? (NUM_REQ'(1) << id) : '0);

        // Same-address pairs involving a write cannot share a cycle; read/read may.
        always_comb begin
            blocked_out = blocked_in;
            if (hit) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (bus.req_addr[id] == bus.req_addr[j] && (bus.req_we[id] || bus.req_we[j])) begin
                        blocked_out[j] = 1'b1;
                    end
                end
            end
        end

        assign port_hit[k] = hit;
        assign port_id[k]  = id;
    end

    assign bus.req_ready = g_port[NUM_PORTS-1].taken_out;

    always_comb begin
        bus.bram_addr = '0;
        bus.bram_we   = '0;
        bus.bram_din  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_hit[p]) begin
                bus.bram_addr[p] = bus.req_addr[port_id[p]];
                bus.bram_we[p]   = bus.req_we[port_id[p]];
                bus.bram_din[p]  = bus.req_din[port_id[p]];
            end
        end
    end

    // Hits fill ports in scan order, so the highest hit port holds the last granted ID.
    always_comb begin
        any_grant = 1'b0;
        last_id   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_hit[p]) begin
                any_grant = 1'b1;
                last_id   = port_id[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            tag_q  <= '0;
        end else begin
            rr_ptr <= IW'(rr_next(MAX_IW'(rr_ptr), MAX_IW'(last_id), NUM_REQ, any_grant));
            for (int p = 0; p < NUM_PORTS; p++) begin
                tag_q[p] <= port_tag_t'{vld: port_hit[p] & ~bus.bram_we[p], id: MAX_IW'(port_id[p])};
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (tag_q[p].vld) begin
                bus.rsp_valid[IW'(tag_q[p].id)] = 1'b1;
                bus.rsp_data[IW'(tag_q[p].id)]  = bus.bram_dout[p];
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed-vector bench for bram_port_arbiter with a behavioural dual-port,
// read-old-data BRAM whose unwritten words hold 0x1000_0000 + address.
module tb_bram_port_arbiter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned AW        = 5;

    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS)
    ) bus ();

    bram_port_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // BRAM model: written words tracked separately so no initial preload is needed.
    logic [WIDTH-1:0] wr_mem [DEPTH];
    logic [DEPTH-1:0] wr_vld = '0;

    function automatic logic [WIDTH-1:0] init_word(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    always @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.bram_we[p]) begin
                wr_mem[bus.bram_addr[p]] <= bus.bram_din[p];
                wr_vld[bus.bram_addr[p]] <= 1'b1;
            end
            bus.bram_dout[p] <= wr_vld[bus.bram_addr[p]] ? wr_mem[bus.bram_addr[p]]
                                                         : init_word(int'(bus.bram_addr[p]));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.req_valid[id] = v;
        bus.req_we[id]    = we;
        bus.req_addr[id]  = a;
        bus.req_din[id]   = d;
    endtask

    // Responses for the all-read pattern where requester i reads address i+1.
    task automatic check_rsp(input logic [NUM_REQ-1:0] granted);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(granted));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted[i]) begin
                chk($sformatf("rsp_data%0d", i), 64'(bus.rsp_data[i]), 64'(init_word(i + 1)));
            end
        end
    endtask

    task automatic all_read();
        for (int i = 0; i < NUM_REQ; i++) begin
            drive(i, 1'b1, 1'b0, AW'(i + 1), '0);
        end
    endtask

    task automatic all_idle();
        for (int i = 0; i < NUM_REQ; i++) begin
            drive(i, 1'b0, 1'b0, '0, '0);
        end
    endtask

    logic [NUM_REQ-1:0] prev;
    logic [NUM_REQ-1:0] exp_rdy;

    initial begin
        reset = 1'b0;
        all_read();

        // Reset held with every requester valid.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("rst_ready", 64'(bus.req_ready), 64'h0);
            chk("rst_bram_we", 64'(bus.bram_we), 64'h0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        end
        reset = 1'b1;
        #1;

        // All four reading distinct addresses: pairs alternate {0,1},{2,3}.
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            chk("rr_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("rr_port0_addr", 64'(bus.bram_addr[0]), (c % 2 == 0) ? 64'd1 : 64'd3);
            chk("rr_port1_addr", 64'(bus.bram_addr[1]), (c % 2 == 0) ? 64'd2 : 64'd4);
            check_rsp(prev);
            prev = exp_rdy;
        end
        @(posedge clk); #1;
        all_idle();
        #1;
        chk("idle_ready", 64'(bus.req_ready), 64'h0);
        check_rsp(prev);

        // Write/read conflict on address 5: write wins, read follows next cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, AW'(5), 32'h0000_A5A5);
        drive(1, 1'b1, 1'b0, AW'(5), '0);
        #1;
        chk("wr_conf_ready", 64'(bus.req_ready), 64'b0001);
        chk("wr_conf_we", 64'(bus.bram_we), 64'b01);
        chk("wr_conf_addr0", 64'(bus.bram_addr[0]), 64'd5);
        chk("wr_conf_din0", 64'(bus.bram_din[0]), 64'h0000_A5A5);
        chk("wr_conf_addr1", 64'(bus.bram_addr[1]), 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rd_after_wr_ready", 64'(bus.req_ready), 64'b0010);
        chk("rd_after_wr_addr0", 64'(bus.bram_addr[0]), 64'd5);
        chk("wr_no_rsp", 64'(bus.rsp_valid), 64'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rd_after_wr_rsp", 64'(bus.rsp_valid), 64'b0010);
        chk("rd_after_wr_data", 64'(bus.rsp_data[1]), 64'h0000_A5A5);

        // Two reads of the same address share the cycle.
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, AW'(7), '0);
        drive(3, 1'b1, 1'b0, AW'(7), '0);
        #1;
        chk("rr_same_ready", 64'(bus.req_ready), 64'b1100);
        chk("rr_same_addr0", 64'(bus.bram_addr[0]), 64'd7);
        chk("rr_same_addr1", 64'(bus.bram_addr[1]), 64'd7);
        @(posedge clk); #1;
        all_idle();
        #1;
        chk("rr_same_rsp", 64'(bus.rsp_valid), 64'b1100);
        chk("rr_same_data2", 64'(bus.rsp_data[2]), 64'h1000_0007);
        chk("rr_same_data3", 64'(bus.rsp_data[3]), 64'h1000_0007);

        // A blocked candidate does not stop a later one from taking the free port.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, AW'(12), 32'h0000_1234);
        drive(2, 1'b1, 1'b0, AW'(12), '0);
        drive(3, 1'b1, 1'b0, AW'(13), '0);
        #1;
        chk("skip_ready", 64'(bus.req_ready), 64'b1010);
        chk("skip_we", 64'(bus.bram_we), 64'b01);
        chk("skip_addr1", 64'(bus.bram_addr[1]), 64'd13);
        @(posedge clk); #1;
        all_idle();
        #1;
        chk("skip_rsp", 64'(bus.rsp_valid), 64'b1000);
        chk("skip_data3", 64'(bus.rsp_data[3]), 64'h1000_000D);

        // Lone requester 3 from pointer 0; pointer wraps back to 0.
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b0, AW'(9), '0);
        #1;
        chk("lone_ready", 64'(bus.req_ready), 64'b1000);
        chk("lone_addr0", 64'(bus.bram_addr[0]), 64'd9);
        chk("lone_we", 64'(bus.bram_we), 64'b00);
        chk("lone_addr1", 64'(bus.bram_addr[1]), 64'd0);
        chk("lone_din1", 64'(bus.bram_din[1]), 64'd0);
        @(posedge clk); #1;
        all_read();
        #1;
        chk("wrap_ready", 64'(bus.req_ready), 64'b0011);
        chk("lone_rsp", 64'(bus.rsp_valid), 64'b1000);
        chk("lone_data3", 64'(bus.rsp_data[3]), 64'h1000_0009);

        // Reset right after a read grant drops the response and clears the pointer.
        @(posedge clk); #1;
        reset = 1'b0;
        all_idle();
        #1;
        chk("rst_drop_rsp", 64'(bus.rsp_valid), 64'h0);
        chk("rst_drop_data0", 64'(bus.rsp_data[0]), 64'h0);
        chk("rst_drop_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk); #1;
        chk("rst_hold_rsp", 64'(bus.rsp_valid), 64'h0);
        reset = 1'b1;
        all_read();
        #1;
        chk("rst_ptr_ready", 64'(bus.req_ready), 64'b0011);
        @(posedge clk); #2;
        chk("post_rst_ready", 64'(bus.req_ready), 64'b1100);
        check_rsp(4'b0011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
